work_scheduler: RTL and testbench

WORK_SCHEDULER -- requirements
Module: work_scheduler

---
 rtl/work_scheduler_if.sv | 28 ++
 rtl/work_scheduler.sv | 111 +++++++++++
 tb/tb_work_scheduler.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/work_scheduler_if.sv
// Host/core handshake bundle for the work scheduler: boot pushes, core enqueues,
// grant dispatch and status. master = host/cores side, slave = scheduler.
interface work_scheduler_if #(
  parameter int NCORES = 4,
  parameter int DEPTH  = 16
);
  logic                      boot_valid;
  logic [15:0]               boot_pc;
  logic                      boot_ready;
  logic [NCORES-1:0]         core_req;
  logic [NCORES-1:0]         enq_valid;
  logic [16*NCORES-1:0]      enq_pc;
  logic [NCORES-1:0]         enq_ack;
  logic [NCORES-1:0]         grant;
  logic [15:0]               grant_pc;
  logic [$clog2(DEPTH):0]    count;
  logic                      all_done;

  modport master (
    output boot_valid, boot_pc, core_req, enq_valid, enq_pc,
    input  boot_ready, enq_ack, grant, grant_pc, count, all_done
  );

  modport slave (
    input  boot_valid, boot_pc, core_req, enq_valid, enq_pc,
    output boot_ready, enq_ack, grant, grant_pc, count, all_done
  );
endinterface

// File: rtl/work_scheduler.sv
// Work-PC FIFO shared by NCORES cores: one push per cycle (boot first, then lowest core),
// one registered round-robin grant per cycle; acks are combinational, full blocks pushes.
module work_scheduler #(
  parameter int NCORES = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  work_scheduler_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

  logic [15:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q;
  logic [NCORES-1:0] pending;
  logic [IW-1:0]     rr_start;
  logic [NCORES-1:0] grant_q;
  logic [15:0]       grant_pc_q;
  logic              done_q;

  logic [NCORES-1:0] want, sel_oh, gnt_oh, ack;
  logic [IW-1:0]     sel_idx, rr_next, cand;
  logic              found, pop, push, can_push, taken, boot_rdy, done_next;
  logic [15:0]       push_pc;

  always_comb begin
    want    = pending | bus.core_req;
    sel_oh  = '0;
    sel_idx = '0;
    cand    = '0;
    found   = 1'b0;
    // Search begins one past the last grantee and wraps at NCORES-1.
    for (int off = 0; off < NCORES; off++) begin
      if (int'(rr_start) + off >= NCORES)
        cand = IW'(int'(rr_start) + off - NCORES);
      else
        cand = IW'(int'(rr_start) + off);
      if (!found && want[cand]) begin
        found       = 1'b1;
        sel_oh[cand] = 1'b1;
        sel_idx     = cand;
      end
    end
    pop      = found && (count_q != '0);
    gnt_oh   = pop ? sel_oh : '0;
    rr_next  = (sel_idx == IW'(NCORES - 1)) ? '0 : sel_idx + IW'(1);
    // A pop frees the head slot this cycle, so a full FIFO can still take a push.
    can_push = (count_q < CW'(DEPTH)) || pop;

    push     = 1'b0;
    taken    = 1'b0;
    boot_rdy = 1'b0;
    ack      = '0;
    push_pc  = bus.boot_pc;
    if (bus.boot_valid) begin
      boot_rdy = can_push;
      push     = can_push;
    end else begin
      for (int i = 0; i < NCORES; i++) begin
        if (!taken && bus.enq_valid[i]) begin
          taken   = 1'b1;
          ack[i]  = can_push;
          push    = can_push;
          push_pc = bus.enq_pc[16*i +: 16];
        end
      end
    end

    done_next = (count_q == '0) && (&pending) && (bus.enq_valid == '0) &&
                !bus.boot_valid && (grant_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      pending    <= '0;
      rr_start   <= '0;
      grant_q    <= '0;
      grant_pc_q <= '0;
      done_q     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        grant_pc_q <= mem[rd_ptr];
        rr_start   <= rr_next;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
      // A request arriving in the grant cycle is absorbed by that grant.
      pending <= want & ~gnt_oh;
      grant_q <= gnt_oh;
      done_q  <= done_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_pc;
  end

  assign bus.boot_ready = boot_rdy;
  assign bus.enq_ack    = ack;
  assign bus.grant      = grant_q;
  assign bus.grant_pc   = grant_pc_q;
  assign bus.count      = count_q;
  assign bus.all_done   = done_q;
endmodule

// File: tb/tb_work_scheduler.sv
// Scoreboard bench for work_scheduler: queue-based reference model predicts acks,
// occupancy, done and grants; a monitor compares against the DUT each cycle.
`timescale 1ns/1ps
module tb_work_scheduler;
  localparam int NC = 4;
  localparam int DP = 16;

  typedef struct {
    int            cyc;
    logic          br;
    logic [NC-1:0] ack;
    int            cnt;
    logic          done;
  } rec_t;

  typedef struct {
    int          cyc;
    int          core;
    logic [15:0] pc;
  } gnt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  work_scheduler_if #(.NCORES(NC), .DEPTH(DP)) bus ();
  work_scheduler #(.NCORES(NC), .DEPTH(DP)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  rec_t rq[$];
  gnt_t gq[$];
  logic [15:0] last_pc = '0;

  // Reference model state
  logic [15:0] mq[$];
  bit          mpend[NC];
  int          mrr = 0;
  bit          mgrant_prev = 0;
  bit          mdone = 0;
  // Core enqueue agents: request held until acked
  bit          eo[NC];
  logic [15:0] ep[NC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit bv, input logic [15:0] bpc, input logic [NC-1:0] creq);
    rec_t r;
    gnt_t g;
    int sel, win, c;
    bit pop, can, all_p;
    logic [NC-1:0] ev;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NC; i++) begin
      ev[i] = eo[i];
      bus.enq_pc[16*i +: 16] = ep[i];
    end
    bus.boot_valid = bv;
    bus.boot_pc    = bpc;
    bus.core_req   = creq;
    bus.enq_valid  = ev;

    r.cyc = cyc; r.cnt = mq.size(); r.done = mdone; r.br = 1'b0; r.ack = '0;
    sel = -1;
    if (mq.size() > 0)
      for (int k = 0; k < NC; k++) begin
        c = (mrr + k) % NC;
        if (sel < 0 && (mpend[c] || creq[c])) sel = c;
      end
    pop = (sel >= 0);
    can = (mq.size() < DP) || pop;
    win = -1;
    for (int i = 0; i < NC; i++) if (win < 0 && ev[i]) win = i;
    all_p = 1;
    for (int i = 0; i < NC; i++) all_p &= mpend[i];
    mdone = (mq.size() == 0) && all_p && (ev == '0) && !bv && !mgrant_prev;
    for (int i = 0; i < NC; i++) if (creq[i]) mpend[i] = 1;
    if (pop) begin
      g.cyc = cyc + 1; g.core = sel; g.pc = mq.pop_front();
      gq.push_back(g);
      mpend[sel] = 0;
      mrr = (sel + 1) % NC;
    end
    mgrant_prev = pop;
    if (can) begin
      if (bv) begin
        r.br = 1'b1; mq.push_back(bpc);
      end else if (win >= 0) begin
        r.ack[win] = 1'b1; mq.push_back(ep[win]); eo[win] = 0;
      end
    end
    rq.push_back(r);
  endtask

  task automatic idle(input int n, input logic [NC-1:0] creq);
    for (int i = 0; i < n; i++) step(0, 16'h0, creq);
  endtask

  // Async pulse between edges, after this cycle's monitor sample.
  task automatic mid_reset();
    #3;
    rst = 1'b1;
    bus.boot_valid = 0; bus.core_req = '0; bus.enq_valid = '0;
    #0.5;
    chk("rst_count", bus.count, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_all_done", bus.all_done, 0);
    chk("rst_grant_pc", bus.grant_pc, 0);
    #0.5;
    rst = 1'b0;
    mq.delete(); gq.delete(); rq.delete();
    for (int i = 0; i < NC; i++) begin mpend[i] = 0; eo[i] = 0; end
    mrr = 0; mgrant_prev = 0; mdone = 0; last_pc = '0;
  endtask

  // Monitor
  initial begin
    rec_t r;
    gnt_t g;
    forever begin
      @(negedge clk);
      #2;
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        chk("boot_ready", bus.boot_ready, r.br);
        chk("enq_ack", bus.enq_ack, r.ack);
        chk("count", bus.count, r.cnt);
        chk("all_done", bus.all_done, r.done);
      end
      if (bus.grant != '0) begin
        if (gq.size() == 0) chk("grant_unexpected", bus.grant, 0);
        else begin
          g = gq.pop_front();
          chk("grant_cycle", cyc, g.cyc);
          chk("grant", bus.grant, 1 << g.core);
          chk("grant_pc", bus.grant_pc, g.pc);
          last_pc = g.pc;
        end
      end else begin
        if (gq.size() > 0 && gq[0].cyc <= cyc) begin
          g = gq.pop_front();
          chk("grant_missing", bus.grant, 1 << g.core);
        end
        chk("grant_pc_hold", bus.grant_pc, last_pc);
      end
    end
  end

  // Stimulus
  initial begin
    logic [NC-1:0] creq;
    bit bv;
    bus.boot_valid = 0; bus.boot_pc = '0; bus.core_req = '0;
    bus.enq_valid = '0; bus.enq_pc = '0;
    for (int i = 0; i < NC; i++) begin mpend[i] = 0; eo[i] = 0; ep[i] = '0; end
    #3;
    chk("init_count", bus.count, 0);
    chk("init_grant", bus.grant, 0);
    chk("init_grant_pc", bus.grant_pc, 0);
    chk("init_all_done", bus.all_done, 0);
    #4 rst = 1'b0;

    // Boot then dispatch
    step(1, 16'h0100, '0);
    step(1, 16'h0200, '0);
    step(0, 16'h0, 4'b0011);
    idle(3, '0);

    // Round-robin from core 2 after last grant to core 1
    for (int i = 0; i < 4; i++) step(1, 16'h1000 + 16'(i), '0);
    step(0, 16'h0, 4'b1111);
    idle(6, '0);

    // Full FIFO, core 3 enqueue waits for a pop
    for (int i = 0; i < DP; i++) step(1, 16'h2000 + 16'(i), '0);
    eo[3] = 1; ep[3] = 16'hBEEF;
    idle(3, '0);
    step(0, 16'h0, 4'b0001);
    for (int i = 0; i < 20; i++) step(0, 16'h0, 4'b1111);
    idle(2, '0);

    // Boot beats enq; then lowest core index
    eo[1] = 1; ep[1] = 16'h1111;
    eo[2] = 1; ep[2] = 16'h2222;
    step(1, 16'h0AAA, '0);
    idle(2, '0);

    // Drain, all cores idle-pending, then a new enqueue clears done
    step(0, 16'h0, 4'b1111);
    idle(4, '0);
    step(0, 16'h0, 4'b1111);
    idle(3, '0);
    eo[0] = 1; ep[0] = 16'h3333;
    idle(3, '0);
    step(0, 16'h0, 4'b1111);
    idle(2, '0);

    // Reset mid-run with occupancy and pending requests
    for (int i = 0; i < 5; i++) step(1, 16'h4000 + 16'(i), '0);
    step(0, 16'h0, 4'b0011);
    mid_reset();
    idle(4, '0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NC; i++)
        if (!eo[i] && $urandom_range(0, 5) == 0) begin
          eo[i] = 1; ep[i] = 16'($urandom);
        end
      bv = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NC; i++) creq[i] = ($urandom_range(0, 7) == 0);
      step(bv, 16'($urandom), creq);
    end

    // Drain everything
    for (int i = 0; i < 30; i++) step(0, 16'h0, 4'b1111);
    idle(3, '0);
    chk("grant_queue_drained", gq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
